// File: rtl/aes_sub_table.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_table
// Purpose  : AES forward S-box, one byte per clock, registered (1-cycle latency)
// Revision : 1.0
// ============================================================================
module aes_sub_table (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    output logic [7:0] out_byte
);

    localparam logic [7:0] c_affineConst = 8'h63;
    localparam logic [7:0] c_reducePoly  = 8'h1B;

    // GF(2^8) multiply, modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? c_reducePoly : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as a^254 by repeated squaring; 0 maps to 0 naturally.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] res;
        pw  = a;
        res = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gfMul(pw, pw);
            res = gfMul(res, pw);
        end
        return res;
    endfunction

    function automatic logic [7:0] sBox(input logic [7:0] x);
        logic [7:0] b;
        b = gfInv(x);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ c_affineConst;
    endfunction

    logic [7:0] w_subByte;
    logic [7:0] r_outByte;
    logic       r_outValid;

    always_comb begin
        w_subByte = sBox(in_byte);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outByte  <= 8'h00;
            r_outValid <= 1'b0;
        end else begin
            r_outByte  <= w_subByte;
            r_outValid <= in_valid;
        end
    end

    assign out_byte  = r_outByte;
    assign out_valid = r_outValid;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sub_table
// Purpose  : Self-checking bench for aes_sub_table against a GF(2^8) model
// Revision : 1.0
// ============================================================================
module tb_aes_sub_table;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic [7:0] out_byte;

    int testCount;
    int failCount;
    logic [7:0] refTable [256];

    aes_sub_table dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_byte  (out_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: full polynomial product, then long division by 0x11B.
    function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = 15'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ ({7'h0, a} << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (15'h11B << (i - 8));
        end
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Inverse by exhaustive search, then the affine transform.
    function automatic logic [7:0] refSbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (refMul(x, y[7:0]) == 8'h01) inv = y[7:0];
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
        testCount++;
        if (got !== expv) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic stepIn(input logic rst, input logic v, input logic [7:0] b);
        rst_n    = rst;
        in_valid = v;
        in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic [7:0] expByte, input logic expValid);
        checkVal({tag, "_byte"}, {24'h0, out_byte}, {24'h0, expByte});
        checkVal({tag, "_valid"}, {31'h0, out_valid}, {31'h0, expValid});
    endtask

    logic [7:0] kwIn  [4];
    logic [7:0] kwOut [4];
    bit         seen  [256];
    int         distinctCount;
    int         fixedCount;
    int         complCount;
    logic       rv;
    logic       rr;
    logic [7:0] rb;

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        for (int i = 0; i < 256; i++) refTable[i] = refSbox(i[7:0]);

        #2;
        // Reset holds outputs at zero despite active inputs
        stepIn(1'b0, 1'b1, 8'hFF);
        checkOut("rst1", 8'h00, 1'b0);
        stepIn(1'b0, 1'b1, 8'hFF);
        checkOut("rst2", 8'h00, 1'b0);
        stepIn(1'b1, 1'b1, 8'hFF);
        checkOut("rst_release", 8'h16, 1'b1);

        // Single vectors against literal expectations
        stepIn(1'b1, 1'b1, 8'h00); checkOut("s00", 8'h63, 1'b1);
        stepIn(1'b1, 1'b1, 8'h01); checkOut("s01", 8'h7C, 1'b1);
        stepIn(1'b1, 1'b1, 8'h53); checkOut("s53", 8'hED, 1'b1);
        stepIn(1'b1, 1'b1, 8'h10); checkOut("s10", 8'hCA, 1'b1);
        stepIn(1'b1, 1'b1, 8'hFF); checkOut("sFF", 8'h16, 1'b1);

        // SubWord of the rotated key word
        kwIn  = '{8'hCF, 8'h4F, 8'h3C, 8'h09};
        kwOut = '{8'h8A, 8'h84, 8'hEB, 8'h01};
        for (int i = 0; i < 4; i++) begin
            stepIn(1'b1, 1'b1, kwIn[i]);
            checkOut($sformatf("subword%0d", i), kwOut[i], 1'b1);
        end

        // Exhaustive sweep against the model, plus permutation properties
        distinctCount = 0;
        fixedCount    = 0;
        complCount    = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            stepIn(1'b1, 1'b1, i[7:0]);
            checkVal($sformatf("sweep%02h", i), {24'h0, out_byte}, {24'h0, refTable[i]});
            if (!seen[out_byte]) distinctCount++;
            seen[out_byte] = 1'b1;
            if (out_byte == i[7:0]) fixedCount++;
            if (out_byte == ~i[7:0]) complCount++;
            if (i == 8'h7F) checkVal("s7F", {24'h0, out_byte}, 32'hD2);
            if (i == 8'h80) checkVal("s80", {24'h0, out_byte}, 32'hCD);
        end
        checkVal("unique", distinctCount, 256);
        checkVal("fixed_points", fixedCount, 0);
        checkVal("compl_points", complCount, 0);

        // Valid gating leaves the data path running
        stepIn(1'b1, 1'b1, 8'h00); checkOut("gate0", 8'h63, 1'b1);
        stepIn(1'b1, 1'b0, 8'h01); checkOut("gate1", 8'h7C, 1'b0);
        stepIn(1'b1, 1'b1, 8'h02); checkOut("gate2", 8'h77, 1'b1);

        // Reset mid-stream
        stepIn(1'b1, 1'b1, 8'h20); checkOut("mid0", refTable[8'h20], 1'b1);
        stepIn(1'b1, 1'b1, 8'h21); checkOut("mid1", refTable[8'h21], 1'b1);
        stepIn(1'b0, 1'b1, 8'h22); checkOut("mid_rst", 8'h00, 1'b0);
        stepIn(1'b1, 1'b1, 8'h23); checkOut("mid_resume", refTable[8'h23], 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 19) != 0);
            rv = 1'($urandom_range(0, 1));
            rb = 8'($urandom_range(0, 255));
            stepIn(rr, rv, rb);
            if (rr) checkOut($sformatf("rand%0d", i), refTable[rb], rv);
            else    checkOut($sformatf("rand%0d", i), 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
